// File: rtl/eval_sequencer_if.sv
// Board RAM read-port bundle shared through the req/gnt arbiter.
//   mem_req : sequencer requests the read port
//   mem_gnt : arbiter grant, may change any cycle
//   rd_en   : read strobe (mem_req & mem_gnt)
//   rd_addr : square index being read
//   rd_data : piece code, valid the cycle after rd_en
// master = evaluator side, slave = arbiter/RAM side.
interface eval_sequencer_if;
    logic       mem_req;
    logic       mem_gnt;
    logic       rd_en;
    logic [5:0] rd_addr;
    logic [3:0] rd_data;

    modport master (
        output mem_req,
        output rd_en,
        output rd_addr,
        input  mem_gnt,
        input  rd_data
    );

    modport slave (
        input  mem_req,
        input  rd_en,
        input  rd_addr,
        output mem_gnt,
        output rd_data
    );
endinterface

// File: rtl/eval_sequencer.sv
// Sequential material evaluator. On start it either reports a latched mate/stalemate
// verdict immediately or scans NUM_SQUARES board squares through the shared RAM port,
// summing signed piece weights (white positive).
// Ports:
//   clk_i, rst_i         : clock, synchronous active-high reset
//   start_i              : evaluation request, sampled only in idle
//   checkmate_i[1:0]     : 10 white mated, 01 black mated, else none
//   stalemate_i          : draw verdict
//   white_to_move_i      : side to move, latched with start_i
//   bus                  : board RAM read port (master side)
//   busy_o               : high while scanning
//   done_o               : one-cycle completion pulse
//   score_o              : white-relative score
//   score_stm_o          : side-to-move-relative score
module eval_sequencer #(
    parameter logic signed [15:0] MATE_SCORE  = 16'sd32000,
    parameter int unsigned        NUM_SQUARES = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [1:0]             checkmate_i,
    input  logic                   stalemate_i,
    input  logic                   white_to_move_i,
    eval_sequencer_if.master       bus,
    output logic                   busy_o,
    output logic                   done_o,
    output logic signed [15:0]     score_o,
    output logic signed [15:0]     score_stm_o
);

    localparam logic [6:0] NumSq = 7'(NUM_SQUARES);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e             state_q, state_d;
    logic signed [15:0] acc_q, acc_d;
    logic signed [15:0] score_q, score_d;
    logic signed [15:0] score_stm_q, score_stm_d;
    logic [6:0]         issued_q, issued_d;
    logic [5:0]         addr_q, addr_d;
    logic               wtm_q, wtm_d;
    logic               pending_q;

    logic               all_issued;
    logic               mem_req;
    logic               rd_en;
    logic signed [15:0] piece_val;
    logic signed [15:0] sum;
    logic signed [15:0] verdict;
    logic               verdict_hit;

    function automatic logic signed [15:0] piece_value(input logic [3:0] code);
        logic signed [15:0] w;
        case (code[2:0])
            3'd1:       w = 16'sd1;
            3'd2, 3'd3: w = 16'sd3;
            3'd4:       w = 16'sd5;
            3'd5:       w = 16'sd10;
            default:    w = 16'sd0;   // empty, king, illegal
        endcase
        return code[3] ? -w : w;
    endfunction

    always_comb begin
        all_issued = (issued_q == NumSq);
        mem_req    = (state_q == StScan) && !all_issued;
        rd_en      = mem_req && bus.mem_gnt;
        // rd_data is only meaningful the cycle after a strobe, regardless of grant now.
        piece_val  = pending_q ? piece_value(bus.rd_data) : 16'sd0;
        sum        = acc_q + piece_val;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        issued_d    = issued_q;
        addr_d      = addr_q;
        wtm_d       = wtm_q;
        score_d     = score_q;
        score_stm_d = score_stm_q;
        verdict     = 16'sd0;
        verdict_hit = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    wtm_d = white_to_move_i;
                    // Checkmate outranks stalemate; 00/11 are not mates.
                    if (checkmate_i == 2'b10) begin
                        verdict     = -MATE_SCORE;
                        verdict_hit = 1'b1;
                    end else if (checkmate_i == 2'b01) begin
                        verdict     = MATE_SCORE;
                        verdict_hit = 1'b1;
                    end else if (stalemate_i) begin
                        verdict_hit = 1'b1;
                    end

                    if (verdict_hit) begin
                        score_d     = verdict;
                        score_stm_d = white_to_move_i ? verdict : -verdict;
                        state_d     = StDone;
                    end else begin
                        acc_d    = 16'sd0;
                        issued_d = 7'd0;
                        addr_d   = 6'd0;
                        state_d  = StScan;
                    end
                end
            end
            StScan: begin
                acc_d = sum;
                if (rd_en) begin
                    addr_d   = addr_q + 6'd1;
                    issued_d = issued_q + 7'd1;
                end
                // Once everything is issued, this cycle carries the final pending datum.
                if (all_issued) begin
                    score_d     = sum;
                    score_stm_d = wtm_q ? sum : -sum;
                    state_d     = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            acc_q       <= 16'sd0;
            issued_q    <= 7'd0;
            addr_q      <= 6'd0;
            wtm_q       <= 1'b0;
            pending_q   <= 1'b0;
            score_q     <= 16'sd0;
            score_stm_q <= 16'sd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            issued_q    <= issued_d;
            addr_q      <= addr_d;
            wtm_q       <= wtm_d;
            pending_q   <= rd_en;
            score_q     <= score_d;
            score_stm_q <= score_stm_d;
        end
    end

    assign bus.mem_req  = mem_req;
    assign bus.rd_en    = rd_en;
    assign bus.rd_addr  = addr_q;
    assign busy_o       = (state_q == StScan);
    assign done_o       = (state_q == StDone);
    assign score_o      = score_q;
    assign score_stm_o  = score_stm_q;

endmodule
